// File: rtl/kcpsm_hub_pkg.sv
// Shared constants for the kcpsm3 port hub: hub register addresses,
// the "no vector" code and the largest supported channel count.
package kcpsm_hub_pkg;

  localparam logic [7:0] ADDR_PAGE   = 8'hF0;
  localparam logic [7:0] ADDR_MASK   = 8'hF1;
  localparam logic [7:0] ADDR_PEND   = 8'hF2;
  localparam logic [7:0] ADDR_VECTOR = 8'hF3;

  localparam logic [7:0] VECTOR_NONE = 8'hFF;

  localparam int MAX_CH = 15;

endpackage

// File: rtl/hub_irq_ctrl.sv
// Edge-triggered interrupt controller for the kcpsm3 port hub.
// Holds the irq_src history, PEND/MASK/VECTOR registers and a
// lowest-index-first priority encoder. A new edge always wins over a
// W1C clear or an ack clear of the same bit in the same cycle.
module hub_irq_ctrl
  import kcpsm_hub_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] irq_src,
  input  logic              wr_mask,
  input  logic              wr_pend,
  input  logic [7:0]        wr_data,
  input  logic              ack,
  output logic [NUM_CH-1:0] mask,
  output logic [NUM_CH-1:0] pend,
  output logic [7:0]        vector,
  output logic              irq
);

  logic [NUM_CH-1:0] src_q_r;
  logic [NUM_CH-1:0] pend_r;
  logic [NUM_CH-1:0] mask_r;
  logic [7:0]        vector_r;
  logic              irq_r;

  logic [NUM_CH-1:0] set_s;
  logic [NUM_CH-1:0] active_s;
  logic [NUM_CH-1:0] first_s;
  logic [NUM_CH-1:0] clr_w1c_s;
  logic [NUM_CH-1:0] clr_ack_s;
  logic [NUM_CH-1:0] pend_next_s;
  logic [7:0]        idx_s;

  // Edge detect, priority encode and next-pending computation.
  always_comb begin
    set_s    = irq_src & ~src_q_r;
    active_s = pend_r & mask_r;
    idx_s    = VECTOR_NONE;
    // Walk from the top down so the lowest active index is the last one kept.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx_s = active_s[i] ? 8'(i) : idx_s;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      first_s[i] = (idx_s == 8'(i));
    end
    clr_w1c_s   = wr_pend ? NUM_CH'(wr_data) : {NUM_CH{1'b0}};
    clr_ack_s   = ack ? first_s : {NUM_CH{1'b0}};
    pend_next_s = (pend_r & ~clr_w1c_s & ~clr_ack_s) | set_s;
  end

  // Interrupt controller state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      src_q_r  <= {NUM_CH{1'b0}};
      pend_r   <= {NUM_CH{1'b0}};
      mask_r   <= {NUM_CH{1'b0}};
      vector_r <= VECTOR_NONE;
      irq_r    <= 1'b0;
    end else begin
      src_q_r <= irq_src;
      pend_r  <= pend_next_s;
      if (wr_mask) begin
        mask_r <= NUM_CH'(wr_data);
      end else begin
        mask_r <= mask_r;
      end
      if (ack) begin
        vector_r <= idx_s;
      end else begin
        vector_r <= vector_r;
      end
      // Drop the request in the cycle after an ack; any bit still pending
      // and unmasked raises it again one cycle later.
      irq_r <= ack ? 1'b0 : (|active_s);
    end
  end

  assign mask   = mask_r;
  assign pend   = pend_r;
  assign vector = vector_r;
  assign irq    = irq_r;

endmodule

// File: rtl/kcpsm_port_hub.sv
// Port-I/O hub between one kcpsm3 core and NUM_CH peripheral channels.
// Decodes port_id into one-hot registered channel strobes, keeps the PAGE
// register, forms the registered channel address/data and muxes read data
// into a registered in_port.
// Build option: define KCPSM_HUB_IRQ_EN to enable the interrupt controller
// (MASK/PEND/VECTOR at 0xF1-0xF3); otherwise those read 0x00 and
// cpu_interrupt stays low.
module kcpsm_port_hub
  import kcpsm_hub_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CH_ADDR_BITS = 4,
  parameter int PAGE_W       = 7
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [7:0]                     cpu_port_id,
  input  logic [7:0]                     cpu_out_port,
  input  logic                           cpu_write_strobe,
  input  logic                           cpu_read_strobe,
  input  logic                           cpu_interrupt_ack,
  output logic [7:0]                     cpu_in_port,
  output logic                           cpu_interrupt,
  output logic [NUM_CH-1:0]              ch_wr,
  output logic [NUM_CH-1:0]              ch_rd,
  output logic [PAGE_W+CH_ADDR_BITS-1:0] ch_addr,
  output logic [7:0]                     ch_wr_data,
  input  logic [8*NUM_CH-1:0]            ch_rd_data,
  input  logic [NUM_CH-1:0]              irq_src
);

  // Channel index field width; NUM_CH << CH_ADDR_BITS <= 240 keeps every
  // channel below the hub register block at 0xF0.
  localparam int IDX_W = 8 - CH_ADDR_BITS;

  logic [PAGE_W-1:0] page_r;
  logic              live_r;

  logic [NUM_CH-1:0] ch_sel_s;
  logic [7:0]        ch_data_s;
  logic [7:0]        rd_mux_s;
  logic              wr_ok_s;
  logic              rd_ok_s;
  logic              wr_mask_s;
  logic              wr_pend_s;
  logic [NUM_CH-1:0] mask_s;
  logic [NUM_CH-1:0] pend_s;
  logic [7:0]        vector_s;
  logic              irq_s;

  // Strobes are only honoured once the hub has been out of reset for a cycle.
  assign wr_ok_s   = cpu_write_strobe & live_r;
  assign rd_ok_s   = cpu_read_strobe & live_r;
  assign wr_mask_s = wr_ok_s & (cpu_port_id == ADDR_MASK);
  assign wr_pend_s = wr_ok_s & (cpu_port_id == ADDR_PEND);

`ifdef KCPSM_HUB_IRQ_EN
  hub_irq_ctrl #(
    .NUM_CH (NUM_CH)
  ) u_irq (
    .clk     (clk),
    .reset   (reset),
    .irq_src (irq_src),
    .wr_mask (wr_mask_s),
    .wr_pend (wr_pend_s),
    .wr_data (cpu_out_port),
    .ack     (cpu_interrupt_ack),
    .mask    (mask_s),
    .pend    (pend_s),
    .vector  (vector_s),
    .irq     (irq_s)
  );
`else
  logic [NUM_CH-1:0] unused_mask;
  logic [NUM_CH-1:0] unused_pend;
  logic [7:0]        unused_vector;
  logic              unused_irq;
  logic              unused_in;

  // Controller held idle with constant inputs so it folds away.
  hub_irq_ctrl #(
    .NUM_CH (NUM_CH)
  ) u_irq (
    .clk     (clk),
    .reset   (reset),
    .irq_src ({NUM_CH{1'b0}}),
    .wr_mask (1'b0),
    .wr_pend (1'b0),
    .wr_data (8'h00),
    .ack     (1'b0),
    .mask    (unused_mask),
    .pend    (unused_pend),
    .vector  (unused_vector),
    .irq     (unused_irq)
  );

  assign mask_s    = {NUM_CH{1'b0}};
  assign pend_s    = {NUM_CH{1'b0}};
  assign vector_s  = 8'h00;
  assign irq_s     = 1'b0;
  assign unused_in = ^{irq_src, cpu_interrupt_ack, wr_mask_s, wr_pend_s};
`endif

  // Channel decode: one-hot select and the matching channel's read data.
  always_comb begin
    ch_sel_s  = {NUM_CH{1'b0}};
    ch_data_s = 8'h00;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cpu_port_id[7:CH_ADDR_BITS] == IDX_W'(c)) begin
        ch_sel_s[c] = 1'b1;
        ch_data_s   = ch_rd_data[8*c +: 8];
      end else begin
        ch_sel_s[c] = 1'b0;
      end
    end
  end

  // Read mux: hub registers first, then channels, unmapped ports give 0x00.
  always_comb begin
    rd_mux_s = 8'h00;
    case (cpu_port_id)
      ADDR_PAGE:   rd_mux_s = 8'(page_r);
      ADDR_MASK:   rd_mux_s = 8'(mask_s);
      ADDR_PEND:   rd_mux_s = 8'(pend_s);
      ADDR_VECTOR: rd_mux_s = vector_s;
      default:     rd_mux_s = ch_data_s;
    endcase
  end

  // PAGE register and the post-reset strobe enable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      page_r <= {PAGE_W{1'b0}};
      live_r <= 1'b0;
    end else begin
      live_r <= 1'b1;
      if (wr_ok_s && (cpu_port_id == ADDR_PAGE)) begin
        page_r <= PAGE_W'(cpu_out_port);
      end else begin
        page_r <= page_r;
      end
    end
  end

  // Registered channel strobes, address, write data and read data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ch_wr       <= {NUM_CH{1'b0}};
      ch_rd       <= {NUM_CH{1'b0}};
      ch_addr     <= {(PAGE_W+CH_ADDR_BITS){1'b0}};
      ch_wr_data  <= 8'h00;
      cpu_in_port <= 8'h00;
    end else begin
      ch_wr       <= wr_ok_s ? ch_sel_s : {NUM_CH{1'b0}};
      ch_rd       <= rd_ok_s ? ch_sel_s : {NUM_CH{1'b0}};
      ch_addr     <= {page_r, cpu_port_id[CH_ADDR_BITS-1:0]};
      ch_wr_data  <= cpu_out_port;
      cpu_in_port <= rd_mux_s;
    end
  end

  assign cpu_interrupt = irq_s;

endmodule

// File: tb/tb_kcpsm_port_hub.sv
// Directed bench for kcpsm_port_hub with default parameters
// (NUM_CH=4, CH_ADDR_BITS=4, PAGE_W=7). Interrupt checks follow the
// KCPSM_HUB_IRQ_EN build option.
module tb_kcpsm_port_hub;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  cpu_port_id;
  logic [7:0]  cpu_out_port;
  logic        cpu_write_strobe;
  logic        cpu_read_strobe;
  logic        cpu_interrupt_ack;
  logic [7:0]  cpu_in_port;
  logic        cpu_interrupt;
  logic [3:0]  ch_wr;
  logic [3:0]  ch_rd;
  logic [10:0] ch_addr;
  logic [7:0]  ch_wr_data;
  logic [31:0] ch_rd_data;
  logic [3:0]  irq_src;

  int total = 0;
  int bad   = 0;
  logic [7:0] v;

  kcpsm_port_hub dut (
    .clk               (clk),
    .reset             (reset),
    .cpu_port_id       (cpu_port_id),
    .cpu_out_port      (cpu_out_port),
    .cpu_write_strobe  (cpu_write_strobe),
    .cpu_read_strobe   (cpu_read_strobe),
    .cpu_interrupt_ack (cpu_interrupt_ack),
    .cpu_in_port       (cpu_in_port),
    .cpu_interrupt     (cpu_interrupt),
    .ch_wr             (ch_wr),
    .ch_rd             (ch_rd),
    .ch_addr           (ch_addr),
    .ch_wr_data        (ch_wr_data),
    .ch_rd_data        (ch_rd_data),
    .irq_src           (irq_src)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kcpsm3 OUTPUT: port_id/out_port for two cycles, write_strobe in the second.
  // Returns just after the edge that registers the strobe.
  task automatic cpu_out(input logic [7:0] p, input logic [7:0] d);
    cpu_port_id  = p;
    cpu_out_port = d;
    tick();
    cpu_write_strobe = 1'b1;
    tick();
    cpu_write_strobe = 1'b0;
  endtask

  // kcpsm3 INPUT: value captured during the read_strobe cycle.
  // Returns just after the edge that registers ch_rd.
  task automatic cpu_in(input logic [7:0] p, output logic [7:0] d);
    cpu_port_id = p;
    tick();
    cpu_read_strobe = 1'b1;
    d = cpu_in_port;
    tick();
    cpu_read_strobe = 1'b0;
  endtask

  task automatic do_ack();
    cpu_interrupt_ack = 1'b1;
    tick();
    cpu_interrupt_ack = 1'b0;
  endtask

  initial begin
    reset             = 1'b0;
    cpu_port_id       = 8'h00;
    cpu_out_port      = 8'h00;
    cpu_write_strobe  = 1'b0;
    cpu_read_strobe   = 1'b0;
    cpu_interrupt_ack = 1'b0;
    ch_rd_data        = {8'h44, 8'h5C, 8'h22, 8'h11};
    irq_src           = 4'b0000;
    repeat (3) tick();

    // Reset state
    check("rst_ch_wr", 16'(ch_wr), 16'h0000);
    check("rst_ch_rd", 16'(ch_rd), 16'h0000);
    check("rst_ch_addr", 16'(ch_addr), 16'h0000);
    check("rst_wr_data", 16'(ch_wr_data), 16'h0000);
    check("rst_in_port", 16'(cpu_in_port), 16'h0000);
    check("rst_irq", 16'(cpu_interrupt), 16'h0000);

    reset = 1'b1;
    repeat (2) tick();

`ifdef KCPSM_HUB_IRQ_EN
    cpu_in(8'hF3, v);
    check("rst_vector", 16'(v), 16'h00FF);
`else
    cpu_in(8'hF3, v);
    check("rst_vector_off", 16'(v), 16'h0000);
`endif
    cpu_in(8'hF0, v);
    check("rst_page", 16'(v), 16'h0000);

    // PAGE write then channel 1 write
    cpu_out(8'hF0, 8'h05);
    check("page_wr_no_strobe", 16'(ch_wr), 16'h0000);
    tick();
    cpu_in(8'hF0, v);
    check("page_read", 16'(v), 16'h0005);
    tick();
    cpu_out(8'h12, 8'hA3);
    check("wr_ch_wr", 16'(ch_wr), 16'h0002);
    check("wr_ch_addr", 16'(ch_addr), 16'h0052);
    check("wr_ch_data", 16'(ch_wr_data), 16'h00A3);
    tick();
    check("wr_pulse_end", 16'(ch_wr), 16'h0000);

    // Channel 2 read with pop one cycle after the strobe cycle
    cpu_port_id = 8'h27;
    tick();
    cpu_read_strobe = 1'b1;
    check("rd_in_port", 16'(cpu_in_port), 16'h005C);
    check("rd_no_early_pop", 16'(ch_rd), 16'h0000);
    tick();
    cpu_read_strobe = 1'b0;
    check("rd_ch_rd", 16'(ch_rd), 16'h0004);
    check("rd_ch_addr", 16'(ch_addr), 16'h0057);
    tick();
    check("rd_pulse_end", 16'(ch_rd), 16'h0000);

    // Other channels
    cpu_in(8'h03, v);
    check("rd_ch0", 16'(v), 16'h0011);
    check("rd_ch0_pop", 16'(ch_rd), 16'h0001);
    tick();
    cpu_in(8'h3F, v);
    check("rd_ch3", 16'(v), 16'h0044);
    check("rd_ch3_pop", 16'(ch_rd), 16'h0008);
    tick();

    // Unmapped ports
    cpu_in(8'h80, v);
    check("unmapped_rd", 16'(v), 16'h0000);
    check("unmapped_no_rd", 16'(ch_rd), 16'h0000);
    tick();
    cpu_out(8'h90, 8'h55);
    check("unmapped_no_wr", 16'(ch_wr), 16'h0000);
    tick();

`ifdef KCPSM_HUB_IRQ_EN
    cpu_out(8'hF1, 8'h0A);
    tick();
    cpu_in(8'hF1, v);
    check("mask_read", 16'(v), 16'h000A);
    irq_src = 4'b1010;
    tick();
    tick();
    check("irq_raised", 16'(cpu_interrupt), 16'h0001);
    cpu_in(8'hF2, v);
    check("pend_both", 16'(v), 16'h000A);

    do_ack();
    check("irq_drop_ack1", 16'(cpu_interrupt), 16'h0000);
    tick();
    check("irq_reassert", 16'(cpu_interrupt), 16'h0001);
    cpu_in(8'hF3, v);
    check("vector_ack1", 16'(v), 16'h0001);
    cpu_in(8'hF2, v);
    check("pend_ack1", 16'(v), 16'h0008);

    do_ack();
    tick();
    tick();
    check("irq_low_ack2", 16'(cpu_interrupt), 16'h0000);
    cpu_in(8'hF3, v);
    check("vector_ack2", 16'(v), 16'h0003);
    cpu_in(8'hF2, v);
    check("pend_ack2", 16'(v), 16'h0000);

    do_ack();
    tick();
    cpu_in(8'hF3, v);
    check("vector_none", 16'(v), 16'h00FF);

    // Masked bit still latches; set beats W1C in the same cycle
    irq_src = 4'b1011;
    tick();
    irq_src = 4'b1010;
    tick();
    tick();
    check("masked_no_irq", 16'(cpu_interrupt), 16'h0000);
    cpu_in(8'hF2, v);
    check("masked_latch", 16'(v), 16'h0001);
    cpu_port_id  = 8'hF2;
    cpu_out_port = 8'h01;
    tick();
    cpu_write_strobe = 1'b1;
    irq_src          = 4'b1011;
    tick();
    cpu_write_strobe = 1'b0;
    cpu_in(8'hF2, v);
    check("set_beats_w1c", 16'(v), 16'h0001);
    cpu_out(8'hF2, 8'h01);
    tick();
    cpu_in(8'hF2, v);
    check("w1c_clear", 16'(v), 16'h0000);
`else
    cpu_out(8'hF1, 8'hFF);
    tick();
    cpu_in(8'hF1, v);
    check("mask_off", 16'(v), 16'h0000);
    irq_src = 4'b1111;
    repeat (3) tick();
    check("irq_off", 16'(cpu_interrupt), 16'h0000);
    cpu_in(8'hF2, v);
    check("pend_off", 16'(v), 16'h0000);
`endif

    // Reset arriving while a write strobe is pending
    irq_src = 4'b0000;
    tick();
    cpu_port_id  = 8'h12;
    cpu_out_port = 8'h77;
    tick();
    cpu_write_strobe = 1'b1;
    reset            = 1'b0;
    tick();
    check("rst_mid_wr0", 16'(ch_wr), 16'h0000);
    reset = 1'b1;
    tick();
    check("rst_mid_wr1", 16'(ch_wr), 16'h0000);
    cpu_write_strobe = 1'b0;
    tick();
    check("rst_mid_wr2", 16'(ch_wr), 16'h0000);
    cpu_in(8'hF0, v);
    check("rst_mid_page", 16'(v), 16'h0000);
    cpu_in(8'hF2, v);
    check("rst_mid_pend", 16'(v), 16'h0000);
    cpu_in(8'hF1, v);
    check("rst_mid_mask", 16'(v), 16'h0000);
`ifdef KCPSM_HUB_IRQ_EN
    cpu_in(8'hF3, v);
    check("rst_mid_vector", 16'(v), 16'h00FF);
`else
    cpu_in(8'hF3, v);
    check("rst_mid_vector_off", 16'(v), 16'h0000);
`endif
    check("rst_mid_irq", 16'(cpu_interrupt), 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
